// File: rtl/arb_pkg.sv
// Shared definitions for the rr_arbiter8 round-robin arbiter.
package arb_pkg;

    // Widest requester vector the downstream 8:3 grant encoder accepts.
    localparam int unsigned ARB_N_MAX = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Priority pointer after a win: the slot just past the winner, wrapping modulo n.
    function automatic int unsigned rr_next_ptr(input int unsigned winner, input int unsigned n);
        return (winner + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker. Returns a one-hot vector selecting the first
// set request at or after ptr (wrapping), or all-zero when nothing is requested.
module rr_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_iso;

    // Lower half holds only requesters at or above ptr; upper half holds all of them, so
    // the lowest set bit of the double vector is the rotating-priority winner.
    always_comb begin
        w_mask = {N{1'b1}} << ptr;
        w_dbl  = {req, req & w_mask};
        w_iso  = w_dbl & (~w_dbl + (2*N)'(1));
        pick   = w_iso[N-1:0] | w_iso[2*N-1:N];
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, held until the owner drops its request.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         timeout
);

    localparam int unsigned PtrW = $clog2(N);

    if (N < 2 || N > ARB_N_MAX || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_arbiter8: N must be 2..8 and MAX_HOLD must be >= 1");
    end

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_ptr_nxt;
    logic [N-1:0]    w_pick;
    logic            w_owner_req;
    int unsigned     w_win;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
`endif

    rr_pick #(
        .N (N)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick)
    );

    // Index of the picked requester and whether the current owner still wants the grant.
    always_comb begin
        w_win = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_pick[i]) begin
                w_win = i;
            end
        end
        w_owner_req = |(req & r_gnt);
    end

    // Next-state logic: arbitrate in IDLE, hold in GRANT until release (or forced timeout).
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_busy_nxt    = r_busy;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (|req) begin
                    w_gnt_nxt   = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_ptr_nxt   = PtrW'(rr_next_ptr(w_win, N));
                    w_state_nxt = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                // A coinciding release wins over the timeout, so timeout stays low then.
                if (!w_owner_req) begin
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ARB_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_cnt == CntW'(MAX_HOLD - 1)) begin
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
`endif
            end
            default: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: cycles spent in the current grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
